// File: rtl/lpc_host_pkg.sv
// ---------------------------------------------------------------------------
// lpc_host_pkg
// Shared LPC definitions used by the host-side I/O-cycle engine:
//   - START / CYCTYPE nibble codes (LPC_START, LPC_IO_READ, LPC_IO_WRITE)
//   - SYNC codes returned by the peripheral
//   - host FSM state encodings
// ---------------------------------------------------------------------------
package lpc_host_pkg;

  // Frame codes
  localparam logic [3:0] LPC_START    = 4'b0000;
  localparam logic [3:0] LPC_IO_READ  = 4'b0000;
  localparam logic [3:0] LPC_IO_WRITE = 4'b0010;

  // SYNC codes
  localparam logic [3:0] LPC_SYNC_READY = 4'b0000;
  localparam logic [3:0] LPC_SYNC_SWAIT = 4'b0101;
  localparam logic [3:0] LPC_SYNC_LWAIT = 4'b0110;
  localparam logic [3:0] LPC_SYNC_ERROR = 4'b1010;

  // Value driven in TAR0 and while aborting
  localparam logic [3:0] LPC_TAR = 4'b1111;

  // Host FSM states
  typedef enum logic [4:0] {
    ST_IDLE    = 5'd0,
    ST_START   = 5'd1,
    ST_CYCTYPE = 5'd2,
    ST_ADDR0   = 5'd3,
    ST_ADDR1   = 5'd4,
    ST_ADDR2   = 5'd5,
    ST_ADDR3   = 5'd6,
    ST_WDATA0  = 5'd7,
    ST_WDATA1  = 5'd8,
    ST_TAR0    = 5'd9,
    ST_TAR1    = 5'd10,
    ST_SYNC    = 5'd11,
    ST_RDATA0  = 5'd12,
    ST_RDATA1  = 5'd13,
    ST_PTAR0   = 5'd14,
    ST_PTAR1   = 5'd15,
    ST_ABORT   = 5'd16
  } host_state_e;

endpackage

// File: rtl/lpc_host.sv
// ---------------------------------------------------------------------------
// lpc_host
// Host-side LPC I/O-cycle engine. Accepts single-byte I/O read/write
// requests, sequences LFRAME#/LAD through START, CYCTYPE, address, data,
// turn-around and SYNC, and returns read data plus completion status.
//
// Ports:
//   clk_i, rst_i      LPC clock; asynchronous active-high reset
//   host_req_i        request strobe, accepted while host_busy_o=0
//   host_wr_i         1 = I/O write, 0 = I/O read (latched on accept)
//   host_addr_i[15:0] I/O address (latched on accept)
//   host_wdata_i[7:0] write data (latched on accept)
//   host_rdata_o[7:0] read data, valid with host_done_o after a read
//   host_busy_o       cycle in progress
//   host_done_o       one-clock completion pulse
//   host_err_o        error status, valid with host_done_o
//   lframe_o          LFRAME#, active low
//   lad_bus[3:0]      LAD, tristated whenever the host is not driving
//
// Build option: define LPC_HOST_SYNC_TIMEOUT_EN to abort a cycle after
// SYNC_TIMEOUT consecutive wait-code SYNC clocks.
// ---------------------------------------------------------------------------
module lpc_host
  import lpc_host_pkg::*;
#(
  parameter int unsigned SYNC_TIMEOUT = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        host_req_i,
  input  logic        host_wr_i,
  input  logic [15:0] host_addr_i,
  input  logic [7:0]  host_wdata_i,
  output logic [7:0]  host_rdata_o,
  output logic        host_busy_o,
  output logic        host_done_o,
  output logic        host_err_o,
  output logic        lframe_o,
  inout  wire  [3:0]  lad_bus
);

  host_state_e state_q, state_d;

  logic        wr_q;
  logic [15:0] addr_q;
  logic [7:0]  wdata_q;
  logic        err_q, err_d;
  logic        done_d;
  logic [1:0]  nores_cnt_q, nores_cnt_d;
  logic [1:0]  abort_cnt_q, abort_cnt_d;
  logic        lframe_q, lframe_d;
  logic [3:0]  lad_q, lad_d;
  logic        lad_oe_q, lad_oe_d;
  logic        is_wait;
  logic        timeout_hit;

  assign lad_bus  = lad_oe_q ? lad_q : 4'bzzzz;
  assign lframe_o = lframe_q;

  assign is_wait = (state_q == ST_SYNC) &&
                   ((lad_bus == LPC_SYNC_SWAIT) || (lad_bus == LPC_SYNC_LWAIT));

`ifdef LPC_HOST_SYNC_TIMEOUT_EN
  logic [15:0] wait_cnt_q;

  // Counts consecutive wait codes; anything outside SYNC restarts it, so
  // every SYNC phase begins from zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wait_cnt_q <= '0;
    end else if (is_wait) begin
      wait_cnt_q <= wait_cnt_q + 16'd1;
    end else begin
      wait_cnt_q <= '0;
    end
  end

  // The wait sample that would make the count reach SYNC_TIMEOUT aborts.
  assign timeout_hit = is_wait && (wait_cnt_q == 16'(SYNC_TIMEOUT - 1));
`else
  // Wait codes hold SYNC indefinitely; SYNC_TIMEOUT has no effect here.
  assign timeout_hit = 1'b0;
  if (SYNC_TIMEOUT == 0) begin : g_timeout_unused
  end
`endif

  // Next state, then the registered LAD/LFRAME# values for that state.
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    state_d     = state_q;
    nores_cnt_d = nores_cnt_q;
    abort_cnt_d = abort_cnt_q;
    err_d       = err_q;
    done_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (host_req_i) begin
          state_d = ST_START;
          err_d   = 1'b0;
        end
      end
      ST_START:   state_d = ST_CYCTYPE;
      ST_CYCTYPE: state_d = ST_ADDR0;
      ST_ADDR0:   state_d = ST_ADDR1;
      ST_ADDR1:   state_d = ST_ADDR2;
      ST_ADDR2:   state_d = ST_ADDR3;
      ST_ADDR3:   state_d = wr_q ? ST_WDATA0 : ST_TAR0;
      ST_WDATA0:  state_d = ST_WDATA1;
      ST_WDATA1:  state_d = ST_TAR0;
      ST_TAR0:    state_d = ST_TAR1;
      ST_TAR1: begin
        state_d     = ST_SYNC;
        nores_cnt_d = '0;
      end
      ST_SYNC: begin
        case (lad_bus)
          LPC_SYNC_READY: state_d = wr_q ? ST_PTAR0 : ST_RDATA0;
          LPC_SYNC_ERROR: begin
            err_d   = 1'b1;
            state_d = wr_q ? ST_PTAR0 : ST_RDATA0;
          end
          LPC_SYNC_SWAIT, LPC_SYNC_LWAIT: begin
            nores_cnt_d = '0;
            if (timeout_hit) begin
              state_d     = ST_ABORT;
              abort_cnt_d = '0;
            end
          end
          default: begin
            // Third consecutive unrecognised SYNC value: nobody is answering.
            if (nores_cnt_q == 2'd2) begin
              state_d     = ST_ABORT;
              abort_cnt_d = '0;
            end else begin
              nores_cnt_d = nores_cnt_q + 2'd1;
            end
          end
        endcase
      end
      ST_RDATA0: state_d = ST_RDATA1;
      ST_RDATA1: state_d = ST_PTAR0;
      ST_PTAR0:  state_d = ST_PTAR1;
      ST_PTAR1: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
      ST_ABORT: begin
        if (abort_cnt_q == 2'd3) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          abort_cnt_d = abort_cnt_q + 2'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Decoded from state_d so the registered pins line up with state_q.
    lframe_d = 1'b1;
    lad_d    = LPC_TAR;
    lad_oe_d = 1'b1;
    case (state_d)
      ST_START: begin
        lframe_d = 1'b0;
        lad_d    = LPC_START;
      end
      ST_CYCTYPE: lad_d = wr_q ? LPC_IO_WRITE : LPC_IO_READ;
      ST_ADDR0:   lad_d = addr_q[15:12];
      ST_ADDR1:   lad_d = addr_q[11:8];
      ST_ADDR2:   lad_d = addr_q[7:4];
      ST_ADDR3:   lad_d = addr_q[3:0];
      ST_WDATA0:  lad_d = wdata_q[3:0];
      ST_WDATA1:  lad_d = wdata_q[7:4];
      ST_TAR0:    lad_d = LPC_TAR;
      ST_ABORT:   lframe_d = 1'b0;
      default:    lad_oe_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      err_q        <= 1'b0;
      nores_cnt_q  <= '0;
      abort_cnt_q  <= '0;
      lframe_q     <= 1'b1;
      lad_q        <= '0;
      lad_oe_q     <= 1'b0;
      host_rdata_o <= '0;
      host_busy_o  <= 1'b0;
      host_done_o  <= 1'b0;
      host_err_o   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      err_q       <= err_d;
      nores_cnt_q <= nores_cnt_d;
      abort_cnt_q <= abort_cnt_d;
      lframe_q    <= lframe_d;
      lad_q       <= lad_d;
      lad_oe_q    <= lad_oe_d;
      host_busy_o <= (state_d != ST_IDLE);
      host_done_o <= done_d;
      host_err_o  <= done_d & err_d;

      if (state_q == ST_IDLE && host_req_i) begin
        wr_q    <= host_wr_i;
        addr_q  <= host_addr_i;
        wdata_q <= host_wdata_i;
      end

      if (state_q == ST_RDATA0) host_rdata_o[3:0] <= lad_bus;
      if (state_q == ST_RDATA1) host_rdata_o[7:4] <= lad_bus;
    end
  end

endmodule

// File: tb/tb_lpc_host.sv
// ---------------------------------------------------------------------------
// tb_lpc_host
// Directed bench for lpc_host. A small peripheral stand-in drives SYNC codes
// and read data on LAD; each clock of a cycle is checked against the
// expected LFRAME#/LAD frame, busy/done timing and final status.
// Clock k=0 is the START clock; outputs are sampled mid-clock (negedge+1).
// ---------------------------------------------------------------------------
module tb_lpc_host;
  import lpc_host_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        host_req;
  logic        host_wr;
  logic [15:0] host_addr;
  logic [7:0]  host_wdata;
  logic [7:0]  host_rdata;
  logic        host_busy;
  logic        host_done;
  logic        host_err;
  logic        lframe;
  wire  [3:0]  lad_bus;

  logic [3:0]  per_lad;
  logic        per_oe;
  assign lad_bus = per_oe ? per_lad : 4'bzzzz;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  lpc_host #(.SYNC_TIMEOUT(8)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .host_req_i   (host_req),
    .host_wr_i    (host_wr),
    .host_addr_i  (host_addr),
    .host_wdata_i (host_wdata),
    .host_rdata_o (host_rdata),
    .host_busy_o  (host_busy),
    .host_done_o  (host_done),
    .host_err_o   (host_err),
    .lframe_o     (lframe),
    .lad_bus      (lad_bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Host-driven LAD nibble for clock k (START .. TAR0).
  function automatic logic [3:0] exp_lad(int k, logic wr, logic [15:0] addr, logic [7:0] wdata);
    case (k)
      0:       return 4'b0000;
      1:       return wr ? 4'b0010 : 4'b0000;
      2:       return addr[15:12];
      3:       return addr[11:8];
      4:       return addr[7:4];
      5:       return addr[3:0];
      6:       return wr ? wdata[3:0] : 4'hF;
      7:       return wdata[7:4];
      default: return 4'hF;
    endcase
  endfunction

  // One LPC cycle. Peripheral drives wcode for nwait SYNC clocks, then
  // endcode. In abort mode endcode is repeated until clock ab_k, where the
  // host is expected to start its 4-clock abort.
  task automatic lpc_run(input logic wr, input logic [15:0] addr, input logic [7:0] wdata,
                         input int nwait, input logic [3:0] wcode, input logic [3:0] endcode,
                         input logic [7:0] rdata, input logic exp_err,
                         input logic abort, input int ab_k, input string tag);
    int ss;
    int done_k;
    ss     = wr ? 10 : 8;
    done_k = abort ? ab_k + 4 : 13 + nwait;
    host_wr    = wr;
    host_addr  = addr;
    host_wdata = wdata;
    host_req   = 1'b1;
    @(posedge clk);
    for (int k = 0; k <= done_k; k++) begin
      @(negedge clk);
      if (k == 0) host_req = 1'b0;
      per_oe = 1'b0;
      if (abort) begin
        if (k >= ss && k < ab_k) begin
          per_oe  = 1'b1;
          per_lad = (k < ss + nwait) ? wcode : endcode;
        end
      end else if (k >= ss && k < ss + nwait) begin
        per_oe = 1'b1; per_lad = wcode;
      end else if (k == ss + nwait) begin
        per_oe = 1'b1; per_lad = endcode;
      end else if (!wr && k == ss + nwait + 1) begin
        per_oe = 1'b1; per_lad = rdata[3:0];
      end else if (!wr && k == ss + nwait + 2) begin
        per_oe = 1'b1; per_lad = rdata[7:4];
      end else if (k == done_k - 2) begin
        per_oe = 1'b1; per_lad = 4'hF;
      end
      #1;
      if (k == done_k) begin
        check($sformatf("%s done", tag), host_done, 1'b1);
        check($sformatf("%s busy_end", tag), host_busy, 1'b0);
        check($sformatf("%s err", tag), host_err, exp_err);
        check($sformatf("%s oe_end", tag), dut.lad_oe_q, 1'b0);
        if (!wr && !abort) check($sformatf("%s rdata", tag), host_rdata, rdata);
      end else begin
        check($sformatf("%s k%0d busy", tag, k), host_busy, 1'b1);
        check($sformatf("%s k%0d done", tag, k), host_done, 1'b0);
        if (k <= ss - 2) begin
          check($sformatf("%s k%0d lframe", tag, k), lframe, (k != 0));
          check($sformatf("%s k%0d oe", tag, k), dut.lad_oe_q, 1'b1);
          check($sformatf("%s k%0d lad", tag, k), lad_bus, exp_lad(k, wr, addr, wdata));
        end else if (abort && k >= ab_k) begin
          check($sformatf("%s k%0d ab_lframe", tag, k), lframe, 1'b0);
          check($sformatf("%s k%0d ab_oe", tag, k), dut.lad_oe_q, 1'b1);
          check($sformatf("%s k%0d ab_lad", tag, k), lad_bus, 4'hF);
        end else begin
          check($sformatf("%s k%0d lframe", tag, k), lframe, 1'b1);
          check($sformatf("%s k%0d released", tag, k), dut.lad_oe_q, 1'b0);
        end
      end
    end
    per_oe = 1'b0;
  endtask

  initial begin
    bit seen_done;
    rst        = 1'b1;
    host_req   = 1'b0;
    host_wr    = 1'b0;
    host_addr  = '0;
    host_wdata = '0;
    per_lad    = '0;
    per_oe     = 1'b0;
    #1;
    check("rst lframe", lframe, 1'b1);
    check("rst oe", dut.lad_oe_q, 1'b0);
    check("rst busy", host_busy, 1'b0);
    check("rst done", host_done, 1'b0);
    check("rst err", host_err, 1'b0);
    check("rst rdata", host_rdata, 8'h00);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Back-to-back: each call issues its request in the previous done clock.
    lpc_run(1'b1, 16'h0CA8, 8'h5A, 0, 4'h0, LPC_SYNC_READY, 8'h00, 1'b0, 1'b0, 0, "wr");
    lpc_run(1'b1, 16'h0080, 8'hA5, 0, 4'h0, LPC_SYNC_ERROR, 8'h00, 1'b1, 1'b0, 0, "serr");
    lpc_run(1'b0, 16'h0060, 8'h00, 5, LPC_SYNC_LWAIT, LPC_SYNC_READY, 8'h3C, 1'b0, 1'b0, 0, "rd");
    lpc_run(1'b0, 16'h0060, 8'h00, 0, 4'h0, 4'hF, 8'h00, 1'b1, 1'b1, 11, "nores");

    // Reset in ADDR2 (clock 4).
    host_wr = 1'b1; host_addr = 16'hBEEF; host_wdata = 8'h11; host_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    host_req = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    check("addr2 lad", lad_bus, 4'hE);
    rst = 1'b1;
    #1;
    check("midrst lframe", lframe, 1'b1);
    check("midrst oe", dut.lad_oe_q, 1'b0);
    check("midrst busy", host_busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    lpc_run(1'b1, 16'h1234, 8'hC3, 2, LPC_SYNC_SWAIT, LPC_SYNC_READY, 8'h00, 1'b0, 1'b0, 0, "post_rst");

`ifdef LPC_HOST_SYNC_TIMEOUT_EN
    lpc_run(1'b0, 16'h0060, 8'h00, 100, LPC_SYNC_LWAIT, 4'hF, 8'h00, 1'b1, 1'b1, 16, "tmo");
`else
    // Endless wait codes: the cycle must still be running after 1000 clocks.
    host_wr = 1'b0; host_addr = 16'h0060; host_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    host_req = 1'b0;
    repeat (8) @(negedge clk);
    per_oe    = 1'b1;
    per_lad   = LPC_SYNC_LWAIT;
    seen_done = 1'b0;
    repeat (1000) begin
      @(negedge clk);
      if (host_done) seen_done = 1'b1;
    end
    #1;
    check("hold no_done", seen_done, 1'b0);
    check("hold busy", host_busy, 1'b1);
    rst    = 1'b1;
    per_oe = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
